bist_session_sequencer: RTL and testbench

Sequences a multi-configuration random-test-socket BIST session over a scan-inserted core. For each configuration it runs four steps: request polynomial/seed loading, pulse the BIST register reset, run NUM_ROUNDS shift/capture rounds, then compare the combined MISR/SISA signature against a golden value. It sits between the test host and the PRPG/SRSG/MISR/SISA/core cluster, replacing manual per-configuration resets and done-polling.

---
 rtl/bist_session_sequencer.sv | 167 ++++++++++++++++
 tb/tb_bist_session_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bist_session_sequencer.sv
// BIST session sequencer: for each configuration it loads, resets, runs shift/capture
// rounds and compares the signature, then reports a session-level pass/fail summary.
module bist_session_sequencer #(
    parameter int SHIFT_CNT  = 24,
    parameter int NUM_ROUNDS = 100,
    parameter int NUM_CONFIG = 4,
    parameter int SIG_W      = 40,
    localparam int CFG_W     = (NUM_CONFIG > 1) ? $clog2(NUM_CONFIG) : 1
) (
    input  logic                  clk,
    input  logic                  masterRst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [CFG_W-1:0]      cfg_idx,
    output logic                  cfg_load,
    output logic                  internalRst,
    output logic                  NbarT,
    output logic                  PRPG_En,
    output logic                  SRSG_En,
    output logic                  MISR_En,
    output logic                  SISA_En,
    input  logic [SIG_W-1:0]      sig_in,
    input  logic [SIG_W-1:0]      golden_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [NUM_CONFIG-1:0] fail_map
);

    localparam int SH_W  = $clog2(SHIFT_CNT + 1);
    localparam int RND_W = $clog2(NUM_ROUNDS + 1);
    localparam logic [SH_W-1:0]  SHIFT_LAST = SH_W'(SHIFT_CNT - 1);
    localparam logic [RND_W-1:0] ROUND_LAST = RND_W'(NUM_ROUNDS);
    localparam logic [CFG_W-1:0] CFG_LAST   = CFG_W'(NUM_CONFIG - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_INIT    = 3'd2,
        S_SHIFT   = 3'd3,
        S_CAPTURE = 3'd4,
        S_COMPARE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [SH_W-1:0]       shift_cnt_r;
    logic [RND_W-1:0]      round_cnt_r;
    logic [RND_W-1:0]      round_inc_s;
    logic                  abort_hit_s;
    logic                  sess_start_s;
    logic                  last_shift_s;
    logic                  last_round_s;
    logic                  last_cfg_s;
    logic                  mismatch_s;
    logic [NUM_CONFIG-1:0] cfg_onehot_s;
    logic [NUM_CONFIG-1:0] fail_nxt_s;

    // Decode strobes and the fail map as it would look after this cycle's compare.
    always_comb begin
        abort_hit_s  = abort && (state_r != S_IDLE);
        sess_start_s = (state_r == S_IDLE) && start && !abort;
        last_shift_s = (shift_cnt_r == SHIFT_LAST);
        round_inc_s  = round_cnt_r + RND_W'(1'b1);
        last_round_s = (round_inc_s == ROUND_LAST);
        last_cfg_s   = (cfg_idx == CFG_LAST);
        mismatch_s   = (sig_in != golden_in);
        cfg_onehot_s = NUM_CONFIG'(1'b1) << cfg_idx;
        if ((state_r == S_COMPARE) && mismatch_s) begin
            fail_nxt_s = fail_map | cfg_onehot_s;
        end else begin
            fail_nxt_s = fail_map;
        end
    end

    // Next-state selection; abort overrides every active state.
    always_comb begin
        state_nxt_s = S_IDLE;
        if (abort_hit_s) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:    state_nxt_s = sess_start_s ? S_LOAD : S_IDLE;
                S_LOAD:    state_nxt_s = S_INIT;
                S_INIT:    state_nxt_s = S_SHIFT;
                S_SHIFT:   state_nxt_s = last_shift_s ? S_CAPTURE : S_SHIFT;
                S_CAPTURE: state_nxt_s = last_round_s ? S_COMPARE : S_SHIFT;
                S_COMPARE: state_nxt_s = last_cfg_s ? S_DONE : S_LOAD;
                S_DONE:    state_nxt_s = S_IDLE;
                default:   state_nxt_s = S_IDLE;
            endcase
        end
    end

    // State, counters and Moore outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge masterRst_n) begin
        if (!masterRst_n) begin
            state_r     <= S_IDLE;
            shift_cnt_r <= {SH_W{1'b0}};
            round_cnt_r <= {RND_W{1'b0}};
            cfg_idx     <= {CFG_W{1'b0}};
            cfg_load    <= 1'b0;
            internalRst <= 1'b0;
            NbarT       <= 1'b0;
            PRPG_En     <= 1'b0;
            SRSG_En     <= 1'b0;
            MISR_En     <= 1'b0;
            SISA_En     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_map    <= {NUM_CONFIG{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            cfg_load    <= (state_nxt_s == S_LOAD);
            internalRst <= (state_nxt_s == S_INIT);
            NbarT       <= (state_nxt_s == S_SHIFT);
            SRSG_En     <= (state_nxt_s == S_SHIFT);
            SISA_En     <= (state_nxt_s == S_SHIFT);
            PRPG_En     <= (state_nxt_s == S_CAPTURE);
            MISR_En     <= (state_nxt_s == S_CAPTURE);
            busy        <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
            done        <= (state_nxt_s == S_DONE);

            if ((state_r == S_SHIFT) && (state_nxt_s == S_SHIFT)) begin
                shift_cnt_r <= shift_cnt_r + SH_W'(1'b1);
            end else begin
                shift_cnt_r <= {SH_W{1'b0}};
            end

            if (state_r == S_CAPTURE) begin
                round_cnt_r <= round_inc_s;
            end else if (state_r == S_SHIFT) begin
                round_cnt_r <= round_cnt_r;
            end else begin
                round_cnt_r <= {RND_W{1'b0}};
            end

            if (sess_start_s || abort_hit_s) begin
                cfg_idx <= {CFG_W{1'b0}};
            end else if ((state_r == S_COMPARE) && (state_nxt_s == S_LOAD)) begin
                cfg_idx <= cfg_idx + CFG_W'(1'b1);
            end else begin
                cfg_idx <= cfg_idx;
            end

            // An aborted compare must not record a result.
            if (sess_start_s) begin
                fail_map <= {NUM_CONFIG{1'b0}};
            end else if (!abort_hit_s) begin
                fail_map <= fail_nxt_s;
            end else begin
                fail_map <= fail_map;
            end

            if (abort_hit_s || sess_start_s) begin
                pass <= 1'b0;
            end else if (state_nxt_s == S_DONE) begin
                pass <= ~|fail_nxt_s;
            end else begin
                pass <= pass;
            end
        end
    end

endmodule

// File: tb/tb_bist_session_sequencer.sv
// Randomized bench: two sequencer instances (2/3/2 and 1/1/1) driven with shared random
// start/abort/signature/reset stimulus and checked every cycle against a timeline model.
module tb_bist_session_sequencer;

    localparam int SIG_W = 40;

    logic             clk;
    logic             masterRst_n;
    logic             start;
    logic             abort;
    logic [SIG_W-1:0] sig_in;
    logic [SIG_W-1:0] golden_in;

    logic [0:0] cfg_idx0, cfg_idx1;
    logic       cfg_load0, internalRst0, NbarT0, PRPG_En0, SRSG_En0, MISR_En0, SISA_En0;
    logic       cfg_load1, internalRst1, NbarT1, PRPG_En1, SRSG_En1, MISR_En1, SISA_En1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [1:0] fail_map0;
    logic [0:0] fail_map1;

    bist_session_sequencer #(.SHIFT_CNT(2), .NUM_ROUNDS(3), .NUM_CONFIG(2), .SIG_W(SIG_W)) dut0 (
        .clk(clk), .masterRst_n(masterRst_n), .start(start), .abort(abort),
        .cfg_idx(cfg_idx0), .cfg_load(cfg_load0), .internalRst(internalRst0), .NbarT(NbarT0),
        .PRPG_En(PRPG_En0), .SRSG_En(SRSG_En0), .MISR_En(MISR_En0), .SISA_En(SISA_En0),
        .sig_in(sig_in), .golden_in(golden_in), .busy(busy0), .done(done0), .pass(pass0),
        .fail_map(fail_map0)
    );

    bist_session_sequencer #(.SHIFT_CNT(1), .NUM_ROUNDS(1), .NUM_CONFIG(1), .SIG_W(SIG_W)) dut1 (
        .clk(clk), .masterRst_n(masterRst_n), .start(start), .abort(abort),
        .cfg_idx(cfg_idx1), .cfg_load(cfg_load1), .internalRst(internalRst1), .NbarT(NbarT1),
        .PRPG_En(PRPG_En1), .SRSG_En(SRSG_En1), .MISR_En(MISR_En1), .SISA_En(SISA_En1),
        .sig_in(sig_in), .golden_in(golden_in), .busy(busy1), .done(done1), .pass(pass1),
        .fail_map(fail_map1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] ctl_o  [2];
    logic [2:0] stat_o [2];
    logic [1:0] fmap_o [2];
    logic [0:0] cfg_o  [2];
    assign ctl_o[0]  = {cfg_load0, internalRst0, NbarT0, PRPG_En0, SRSG_En0, MISR_En0, SISA_En0};
    assign ctl_o[1]  = {cfg_load1, internalRst1, NbarT1, PRPG_En1, SRSG_En1, MISR_En1, SISA_En1};
    assign stat_o[0] = {busy0, done0, pass0};
    assign stat_o[1] = {busy1, done1, pass1};
    assign fmap_o[0] = fail_map0;
    assign fmap_o[1] = {1'b0, fail_map1};
    assign cfg_o[0]  = cfg_idx0;
    assign cfg_o[1]  = cfg_idx1;

    int n_checks;
    int n_pass;

    // Reference model: session timeline position, expected fail bits and pass flag.
    int         s_p [2];
    int         r_p [2];
    int         c_p [2];
    bit         in_sess [2];
    int         t_m [2];
    logic [1:0] fail_m [2];
    bit         pass_m [2];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic reset_model(input int i);
        in_sess[i] = 1'b0;
        t_m[i]     = 0;
        fail_m[i]  = 2'b00;
        pass_m[i]  = 1'b0;
    endtask

    task automatic check_inst(input int i);
        int         len, k, off, pos;
        logic [6:0] ctl;
        logic [2:0] stat;
        bit         cfg_valid;
        len       = 3 + r_p[i] * (s_p[i] + 1);
        ctl       = 7'b0;
        stat      = {2'b00, pass_m[i]};
        cfg_valid = 1'b0;
        k         = 0;
        if (in_sess[i]) begin
            if (t_m[i] == c_p[i] * len + 1) begin
                stat = {1'b0, 1'b1, pass_m[i]};
            end else begin
                k         = (t_m[i] - 1) / len;
                off       = (t_m[i] - 1) % len;
                cfg_valid = 1'b1;
                stat[2]   = 1'b1;
                if (off == 0) ctl = 7'b1000000;
                else if (off == 1) ctl = 7'b0100000;
                else if (off < len - 1) begin
                    pos = (off - 2) % (s_p[i] + 1);
                    if (pos < s_p[i]) ctl = 7'b0010101;
                    else ctl = 7'b0001010;
                end
            end
        end
        check_eq($sformatf("ctl%0d", i), {57'b0, ctl_o[i]}, {57'b0, ctl});
        check_eq($sformatf("stat%0d", i), {61'b0, stat_o[i]}, {61'b0, stat});
        check_eq($sformatf("fail_map%0d", i), {62'b0, fmap_o[i]}, {62'b0, fail_m[i]});
        if (cfg_valid) check_eq($sformatf("cfg_idx%0d", i), {63'b0, cfg_o[i]}, 64'(k));
    endtask

    task automatic advance_model(input int i, input bit st, input bit ab, input bit mm);
        int len, off, k;
        len = 3 + r_p[i] * (s_p[i] + 1);
        if (!in_sess[i]) begin
            if (st && !ab) begin
                in_sess[i] = 1'b1;
                t_m[i]     = 1;
                fail_m[i]  = 2'b00;
                pass_m[i]  = 1'b0;
            end
        end else if (ab) begin
            in_sess[i] = 1'b0;
            pass_m[i]  = 1'b0;
        end else if (t_m[i] == c_p[i] * len + 1) begin
            in_sess[i] = 1'b0;
        end else begin
            off = (t_m[i] - 1) % len;
            k   = (t_m[i] - 1) / len;
            if ((off == len - 1) && mm) fail_m[i][k] = 1'b1;
            if (t_m[i] == c_p[i] * len) pass_m[i] = (fail_m[i] == 2'b00);
            t_m[i] = t_m[i] + 1;
        end
    endtask

    initial begin
        bit mm;
        s_p = '{2, 1};
        r_p = '{3, 1};
        c_p = '{2, 1};
        n_checks = 0;
        n_pass   = 0;
        start = 1'b0; abort = 1'b0; sig_in = '0; golden_in = '0;
        masterRst_n = 1'b1;
        #2 masterRst_n = 1'b0;
        reset_model(0);
        reset_model(1);
        #1 check_inst(0);
        check_inst(1);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            check_inst(0);
            check_inst(1);
            if (!masterRst_n) masterRst_n = 1'b1;
            if ((cyc > 3) && ($urandom_range(0, 249) == 0)) begin
                // Asynchronous reset mid-cycle: outputs must clear without a clock edge.
                start = 1'b0;
                abort = 1'b0;
                masterRst_n = 1'b0;
                reset_model(0);
                reset_model(1);
                #1 check_inst(0);
                check_inst(1);
            end else begin
                start     = ($urandom_range(0, 3) == 0);
                abort     = ($urandom_range(0, 89) == 0);
                golden_in = {$urandom, $urandom};
                if ($urandom_range(0, 2) == 0) sig_in = golden_in ^ (SIG_W'(1) << $urandom_range(0, SIG_W - 1));
                else sig_in = golden_in;
                mm = (sig_in != golden_in);
                advance_model(0, start, abort, mm);
                advance_model(1, start, abort, mm);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
